iecdrv_sd_arbiter: RTL
======================

# iecdrv_sd_arbiter

Multiplexes the SD-card block-transfer ports of up to four IEC drive instances onto the single host SD port in the `clk_sys` domain. It sits directly downstream of each drive's `sd_lba`/`sd_blk_cnt`/`sd_rd`/`sd_wr` outputs and upstream of the host SD interface. It grants one drive at a time, round-robin, and holds the grant for a whole transfer. It routes `sd_ack` and the returned buffer data to the granted drive only.

## Interface
Parameters:
- `NDRV`, default 2: number of drive ports, 1..4.

Ports (name, direction, width, meaning):
- `clk_sys` in 1: the single clock.
- `reset` in 1: reset, synchronous, active-high.
- `drv_sd_lba` in NDRV×32: per-drive start LBA.
- `drv_sd_blk_cnt` in NDRV×6: per-drive block count minus 1.
- `drv_sd_rd` in NDRV: per-drive read request, level, held until ack.
- `drv_sd_wr` in NDRV: per-drive write request, level, held until ack.
- `drv_sd_ack` out NDRV: per-drive ack.
- `drv_sd_buff_din` in NDRV×8: per-drive write data, sourced from the drive's buffer.
- `sd_lba` out 32: host start LBA.
- `sd_blk_cnt` out 6: host block count minus 1.
- `sd_rd` out 1: host read request.
- `sd_wr` out 1: host write request.
- `sd_ack` in 1: host ack, high for the whole transfer.
- `sd_buff_din` out 8: write data to host.
- `sd_buff_addr` (14), `sd_buff_dout` (8) and `sd_buff_wr` (1) are not routed by this block. They are broadcast to all drives outside it, because each drive already gates `sd_buff_wr` with its own ack.

## Operation
States: IDLE, REQ, XFER, DONE.

- **IDLE**
  - Waits until `sd_ack`=0.
  - Then picks the first requesting drive (`drv_sd_rd|drv_sd_wr`) searching from `last+1` mod NDRV.
  - Latches `grant`, `lba`, `blk_cnt`, and `op` (wr has priority over rd when both are set on the same drive).
  - Goes to REQ.
- **REQ**
  - Drives `sd_rd`=op==RD and `sd_wr`=op==WR.
  - If `sd_ack` rises, go to XFER.
  - If the granted drive drops both rd and wr before the ack, clear `sd_rd`/`sd_wr` and go to IDLE. The drive is abandoned and `last` is not updated.
- **XFER**
  - `sd_rd`/`sd_wr` are deasserted on entry.
  - Stays in XFER while `sd_ack`=1.
  - Goes to DONE on `sd_ack` falling.
- **DONE**
  - Sets `last`=`grant`, then goes to IDLE.
  - This adds one dead cycle, so a drive's still-high stale request cannot be re-granted before the drive has sampled its ack falling.
- **Routing**
  - `drv_sd_ack[i]` = `sd_ack` & (`grant`==i) & (state∈{REQ,XFER}). This is combinational so it stays aligned with `sd_buff_wr`.
  - `sd_buff_din` = `drv_sd_buff_din[grant]`, combinational.
- **Stable-request rule:** `sd_lba`/`sd_blk_cnt` are registered copies latched at grant. They are held constant from REQ through XFER even if the drive changes its inputs.
- Drive indices ≥ NDRV do not exist. The priority rotation wraps modulo NDRV.

## Timing
- Reset values:
  - state=IDLE, `grant`=0, `last`=NDRV-1 (so drive 0 has first priority).
  - `sd_rd`=`sd_wr`=0, `sd_lba`=0, `sd_blk_cnt`=0, all `drv_sd_ack`=0.
- Request-to-host latency: a request seen in IDLE at cycle t gives `sd_rd`/`sd_wr` high at t+1, with `sd_lba` valid at the same edge.
- Ack routing has zero latency (combinational).
- Min gap between consecutive grants: `sd_ack` fall → DONE (1 cycle) → IDLE (1 cycle) → REQ.
- Reset asserted mid-XFER: state returns to IDLE, and no grant is issued until the host drops `sd_ack`. Acks stay gated off during this time.
- Simultaneous requests on all drives: each is served in order `last+1`, `last+2`, …; no drive waits more than NDRV-1 transfers.
- New request arriving in the same cycle `sd_ack` rises: not considered until IDLE.

## Structure
- Package `iecdrv_sd_pkg`:
  - `state_t` enum {IDLE, REQ, XFER, DONE}.
  - `op_t` {RD, WR}.
  - constant `IECDRV_MAX_DRV`=4.
- Sub-module `iecdrv_rr_pick`: combinational round-robin picker. Inputs are the request vector and `last`; outputs are `valid` and `index`.
- Arbiter top: roughly 150–200 lines.

## Test plan
- **Single read.** Drive 0 rd with lba=0x100, blk_cnt=3.
  - Next cycle: `sd_rd`=1, `sd_lba`=0x100, `sd_blk_cnt`=3.
  - While the host ack is high for 10 cycles, only `drv_sd_ack[0]`=1.
  - `sd_rd` drops on the ack rise.
- **Write with data.** Drive 1 wr. The host reads `sd_buff_din` while acked.
  - Required: `sd_buff_din` equals drive 1's data, and drive 0's data never appears.
- **Contention.** NDRV=4 after reset, all drives request rd.
  - Required grant order 0,1,2,3.
  - Then drive 1 requests again with drive 0 also requesting → drive 0 is served first.
- **Same drive, rd and wr both set.**
  - Required: `sd_wr`=1, `sd_rd`=0.
- **Aborted request.** Drive 2 drops rd while in REQ, before the ack.
  - Required: `sd_rd`=0 next cycle, state IDLE, and drive 3 (pending) is granted after that.
- **Reset mid-XFER.** Pulse `reset` while `sd_ack`=1 with drive 1 granted.
  - Required: all `drv_sd_ack`=0, `sd_rd`/`sd_wr`=0.
  - No new grant until `sd_ack`=0; then drive 0 has priority.

Source files
------------

// File: rtl/iecdrv_sd_arbiter_pkg.sv
// Shared types for the IEC drive SD-card arbiter: FSM states, transfer
// direction and the drive index type sized for the largest drive count.
package iecdrv_sd_pkg;

    localparam int IECDRV_MAX_DRV = 4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        XFER,
        DONE
    } state_t;

    typedef enum logic {
        RD,
        WR
    } op_t;

    typedef logic [1:0] drv_idx_t;

endpackage

// File: rtl/iecdrv_sd_arbiter_if.sv
// Host-side SD block-transfer bus; the arbiter is the master toward the host.
interface iecdrv_sd_arbiter_if;

    logic [31:0] sd_lba;
    logic [5:0]  sd_blk_cnt;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;
    logic [7:0]  sd_buff_din;

    modport master (
        output sd_lba,
        output sd_blk_cnt,
        output sd_rd,
        output sd_wr,
        output sd_buff_din,
        input  sd_ack
    );

    modport slave (
        input  sd_lba,
        input  sd_blk_cnt,
        input  sd_rd,
        input  sd_wr,
        input  sd_buff_din,
        output sd_ack
    );

endinterface

// File: rtl/iecdrv_sd_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping
// modulo NDRV.
module iecdrv_rr_pick
    import iecdrv_sd_pkg::*;
#(
    parameter int NDRV = 2
) (
    input  logic [IECDRV_MAX_DRV-1:0] req,
    input  drv_idx_t                  last,
    output logic                      valid,
    output drv_idx_t                  index
);

    localparam logic [2:0] NDRV3 = 3'(NDRV);

    logic [2:0] cand;

    // Walk from the farthest candidate to the nearest so the nearest wins.
    always_comb begin
        valid = 1'b0;
        index = '0;
        cand  = '0;
        for (int k = NDRV; k >= 1; k--) begin
            cand = {1'b0, last} + 3'(k);
            if (cand >= NDRV3) begin
                cand = cand - NDRV3;
            end
            if (req[cand[1:0]]) begin
                valid = 1'b1;
                index = cand[1:0];
            end
        end
    end

endmodule

// File: rtl/iecdrv_sd_arbiter.sv
// Round-robin arbiter sharing one host SD block port among up to four IEC
// drives; a grant is held for a whole transfer.
module iecdrv_sd_arbiter
    import iecdrv_sd_pkg::*;
#(
    parameter int NDRV = 2
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic [NDRV-1:0][31:0] drv_sd_lba,
    input  logic [NDRV-1:0][5:0]  drv_sd_blk_cnt,
    input  logic [NDRV-1:0]       drv_sd_rd,
    input  logic [NDRV-1:0]       drv_sd_wr,
    output logic [NDRV-1:0]       drv_sd_ack,
    input  logic [NDRV-1:0][7:0]  drv_sd_buff_din,
    iecdrv_sd_arbiter_if.master   host
);

    state_t   state, state_nxt;
    drv_idx_t grant, grant_nxt;
    drv_idx_t last, last_nxt;
    op_t      op_q, op_nxt;
    logic [31:0] lba_q, lba_nxt;
    logic [5:0]  blk_q, blk_nxt;

    logic [IECDRV_MAX_DRV-1:0]       req_pad;
    logic [IECDRV_MAX_DRV-1:0]       wr_pad;
    logic [IECDRV_MAX_DRV-1:0][31:0] lba_pad;
    logic [IECDRV_MAX_DRV-1:0][5:0]  blk_pad;
    logic [IECDRV_MAX_DRV-1:0][7:0]  din_pad;

    logic     pick_valid;
    drv_idx_t pick_idx;
    logic     ack_window;

    assign ack_window = (state == REQ) || (state == XFER);

    // Absent drive slots read as idle so a 2-bit index never selects garbage.
    for (genvar g = 0; g < IECDRV_MAX_DRV; g++) begin : g_drv
        if (g < NDRV) begin : g_real
            assign req_pad[g] = drv_sd_rd[g] | drv_sd_wr[g];
            assign wr_pad[g]  = drv_sd_wr[g];
            assign lba_pad[g] = drv_sd_lba[g];
            assign blk_pad[g] = drv_sd_blk_cnt[g];
            assign din_pad[g] = drv_sd_buff_din[g];
            assign drv_sd_ack[g] = host.sd_ack & (grant == drv_idx_t'(g)) & ack_window;
        end else begin : g_none
            assign req_pad[g] = 1'b0;
            assign wr_pad[g]  = 1'b0;
            assign lba_pad[g] = '0;
            assign blk_pad[g] = '0;
            assign din_pad[g] = '0;
        end
    end

    iecdrv_rr_pick #(
        .NDRV (NDRV)
    ) u_pick (
        .req   (req_pad),
        .last  (last),
        .valid (pick_valid),
        .index (pick_idx)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state <= IDLE;
            grant <= '0;
            last  <= drv_idx_t'(NDRV - 1);
            op_q  <= RD;
            lba_q <= '0;
            blk_q <= '0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            last  <= last_nxt;
            op_q  <= op_nxt;
            lba_q <= lba_nxt;
            blk_q <= blk_nxt;
        end
    end

    // Request parameters are captured only at grant, so the host sees a
    // stable LBA/count even if the drive changes its outputs mid-transfer.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        last_nxt  = last;
        op_nxt    = op_q;
        lba_nxt   = lba_q;
        blk_nxt   = blk_q;
        case (state)
            IDLE: begin
                if (!host.sd_ack && pick_valid) begin
                    grant_nxt = pick_idx;
                    lba_nxt   = lba_pad[pick_idx];
                    blk_nxt   = blk_pad[pick_idx];
                    op_nxt    = wr_pad[pick_idx] ? WR : RD;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (host.sd_ack) begin
                    state_nxt = XFER;
                end else if (!req_pad[grant]) begin
                    state_nxt = IDLE;
                end
            end
            XFER: begin
                if (!host.sd_ack) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                last_nxt  = grant;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign host.sd_rd       = (state == REQ) && (op_q == RD);
    assign host.sd_wr       = (state == REQ) && (op_q == WR);
    assign host.sd_lba      = lba_q;
    assign host.sd_blk_cnt  = blk_q;
    assign host.sd_buff_din = din_pad[grant];

endmodule
